// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants and state encoding for the LM/SM decode-stage sequencer.
package lmsm_sequencer_pkg;

  localparam int          REG_LIST_W = 8;
  localparam logic [3:0]  OPC_LM     = 4'b0110;
  localparam logic [3:0]  OPC_SM     = 4'b0111;
  localparam logic [15:0] NOP_IR     = 16'hF000;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } seqState_t;

  function automatic logic isMultOp(input logic [15:0] ir);
    return (ir[15:12] == OPC_LM) || (ir[15:12] == OPC_SM);
  endfunction

endpackage

// File: rtl/lmsm_sequencer_lowest_bit_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit, the list with
// that bit cleared, and whether any bit is set. Purely combinational.
module lowest_bit_enc
  import lmsm_sequencer_pkg::*;
(
  input  logic [REG_LIST_W-1:0] vec,
  output logic [2:0]            idx,
  output logic [REG_LIST_W-1:0] rest,
  output logic                  any
);

  always_comb begin
    idx = '0;
    // Scanning downward lets the lowest set bit win the final assignment.
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign rest = vec & (vec - REG_LIST_W'(1));
  assign any  = |vec;

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM register lists into one micro-op per selected register, freezing
// PC/pipeline register 1 until the list drains. Build option: LMSM_EMPTY_NOP_EN
// turns an empty-list LM/SM into a bubble via insert_nop.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_in,
  input  logic        stall,
  input  logic        flush,
  output logic        modify_ir,
  output logic [2:0]  modify_pr2_ra,
  output logic        first_multiple,
  output logic        pr1_hold,
  output logic        insert_nop,
  output logic        busy
);

  seqState_t             state, stateNext;
  logic [REG_LIST_W-1:0] mask, maskNext;
  logic [REG_LIST_W-1:0] workList, restList;
  logic [2:0]            curIdx;
  logic                  anyBit;
  logic                  isMult;
  logic                  unusedIrBits;

  assign isMult       = isMultOp(IR_in);
  assign workList     = (state == SEQ) ? mask : IR_in[REG_LIST_W-1:0];
  assign unusedIrBits = ^IR_in[11:REG_LIST_W];

  lowest_bit_enc uEnc (
    .vec  (workList),
    .idx  (curIdx),
    .rest (restList),
    .any  (anyBit)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the mask is real state and must be reset with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      state <= stateNext;
      mask  <= maskNext;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through this block can infer a latch.
    stateNext      = state;
    maskNext       = mask;
    modify_ir      = 1'b0;
    modify_pr2_ra  = '0;
    first_multiple = 1'b0;
    pr1_hold       = 1'b0;
    insert_nop     = 1'b0;
    busy           = (state == SEQ);

    if ((state == SEQ) || (isMult && anyBit)) begin
      modify_ir      = 1'b1;
      modify_pr2_ra  = curIdx;
      first_multiple = (state == IDLE);
      pr1_hold       = |restList;
      maskNext       = restList;
      stateNext      = (|restList) ? SEQ : IDLE;
    end else if (isMult) begin
`ifdef LMSM_EMPTY_NOP_EN
      insert_nop     = 1'b1;
`else
      first_multiple = 1'b1;
`endif
    end

    // Stall re-presents the same micro-op; flush aborts and outranks stall.
    if (stall) begin
      stateNext = state;
      maskNext  = mask;
      pr1_hold  = 1'b1;
    end
    if (flush) begin
      stateNext      = IDLE;
      maskNext       = '0;
      modify_ir      = 1'b0;
      modify_pr2_ra  = '0;
      first_multiple = 1'b0;
      pr1_hold       = 1'b0;
      insert_nop     = 1'b0;
    end

    if (!reset) begin
      modify_ir      = 1'b0;
      modify_pr2_ra  = '0;
      first_multiple = 1'b0;
      pr1_hold       = 1'b0;
      insert_nop     = 1'b0;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed self-checking bench for lmsm_sequencer. Outputs are compared as one
// packed vector {modify_ir, ra[2:0], first_multiple, pr1_hold, insert_nop, busy}.
module tb_lmsm_sequencer;
  import lmsm_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR_in;
  logic        stall;
  logic        flush;
  logic        modify_ir;
  logic [2:0]  modify_pr2_ra;
  logic        first_multiple;
  logic        pr1_hold;
  logic        insert_nop;
  logic        busy;
  logic [7:0]  outs;

  int vecs = 0;
  int errs = 0;

  lmsm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .IR_in          (IR_in),
    .stall          (stall),
    .flush          (flush),
    .modify_ir      (modify_ir),
    .modify_pr2_ra  (modify_pr2_ra),
    .first_multiple (first_multiple),
    .pr1_hold       (pr1_hold),
    .insert_nop     (insert_nop),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign outs = {modify_ir, modify_pr2_ra, first_multiple, pr1_hold, insert_nop, busy};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    IR_in = 16'h66A5;
    stall = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (outs !== 8'b0_000_0_0_0_0)
      begin errs++; $display("FAIL reset_held: got %b want %b", outs, 8'b0_000_0_0_0_0); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (outs !== 8'b1_000_1_1_0_0)
      begin errs++; $display("FAIL reset_first_uop: got %b want %b", outs, 8'b1_000_1_1_0_0); end
    next_cycle();
    // Now in SEQ; an async reset must clear outputs immediately.
    reset = 1'b0;
    #1;
    vecs++;
    if (outs !== 8'b0_000_0_0_0_0)
      begin errs++; $display("FAIL reset_async_midseq: got %b want %b", outs, 8'b0_000_0_0_0_0); end
    next_cycle();
    IR_in = 16'h1234;
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (outs !== 8'b0_000_0_0_0_0)
      begin errs++; $display("FAIL reset_back_idle: got %b want %b", outs, 8'b0_000_0_0_0_0); end
    next_cycle();
  endtask

  task automatic test_multi_lm();
    logic [15:0] ir  [5];
    logic [7:0]  exp [5];
    ir  = '{16'h66A5, 16'h66A5, 16'h66A5, 16'h66A5, 16'h1234};
    exp = '{8'b1_000_1_1_0_0, 8'b1_010_0_1_0_1, 8'b1_101_0_1_0_1,
            8'b1_111_0_0_0_1, 8'b0_000_0_0_0_0};
    for (int i = 0; i < 5; i++) begin
      IR_in = ir[i]; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      vecs++;
      if (outs !== exp[i])
        begin errs++; $display("FAIL multi_lm[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_single_sm();
    logic [15:0] ir  [3];
    logic [7:0]  exp [3];
    ir  = '{16'h7010, 16'h1234, NOP_IR};
    exp = '{8'b1_100_1_0_0_0, 8'b0_000_0_0_0_0, 8'b0_000_0_0_0_0};
    for (int i = 0; i < 3; i++) begin
      IR_in = ir[i]; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      vecs++;
      if (outs !== exp[i])
        begin errs++; $display("FAIL single_sm[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic        st  [8];
    logic [15:0] ir  [8];
    logic [7:0]  exp [8];
    st  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ir  = '{16'h66A5, 16'h66A5, 16'h66A5, 16'h66A5, 16'h66A5, 16'h66A5, 16'h66A5, 16'h1234};
    exp = '{8'b1_000_1_1_0_0, 8'b1_010_0_1_0_1, 8'b1_010_0_1_0_1, 8'b1_010_0_1_0_1,
            8'b1_101_0_1_0_1, 8'b1_111_0_1_0_1, 8'b1_111_0_0_0_1, 8'b0_000_0_0_0_0};
    for (int i = 0; i < 8; i++) begin
      IR_in = ir[i]; stall = st[i]; flush = 1'b0;
      @(negedge clk);
      vecs++;
      if (outs !== exp[i])
        begin errs++; $display("FAIL stall[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    logic        st  [8];
    logic        fl  [8];
    logic [15:0] ir  [8];
    logic [7:0]  exp [8];
    // First pass: plain flush on the ra=5 micro-op. Second: flush with stall.
    st  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fl  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ir  = '{16'h66A5, 16'h66A5, 16'h66A5, 16'h1234, 16'h66A5, 16'h66A5, 16'h66A5, 16'h1234};
    exp = '{8'b1_000_1_1_0_0, 8'b1_010_0_1_0_1, 8'b0_000_0_0_0_1, 8'b0_000_0_0_0_0,
            8'b1_000_1_1_0_0, 8'b1_010_0_1_0_1, 8'b0_000_0_0_0_1, 8'b0_000_0_0_0_0};
    for (int i = 0; i < 8; i++) begin
      IR_in = ir[i]; stall = st[i]; flush = fl[i];
      @(negedge clk);
      vecs++;
      if (outs !== exp[i])
        begin errs++; $display("FAIL flush[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_empty_list();
    logic [7:0] expEmpty;
`ifdef LMSM_EMPTY_NOP_EN
    expEmpty = 8'b0_000_0_0_1_0;
`else
    expEmpty = 8'b0_000_1_0_0_0;
`endif
    IR_in = 16'h6200; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    vecs++;
    if (outs !== expEmpty)
      begin errs++; $display("FAIL empty_list: got %b want %b", outs, expEmpty); end
    next_cycle();
    IR_in = 16'h1234;
    @(negedge clk);
    vecs++;
    if (outs !== 8'b0_000_0_0_0_0)
      begin errs++; $display("FAIL empty_list_after: got %b want %b", outs, 8'b0_000_0_0_0_0); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ir  [4];
    logic [7:0]  exp [4];
    ir  = '{16'h7080, 16'h6603, 16'h6603, 16'h1234};
    exp = '{8'b1_111_1_0_0_0, 8'b1_000_1_1_0_0, 8'b1_001_0_0_0_1, 8'b0_000_0_0_0_0};
    for (int i = 0; i < 4; i++) begin
      IR_in = ir[i]; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      vecs++;
      if (outs !== exp[i])
        begin errs++; $display("FAIL back_to_back[%0d]: got %b want %b", i, outs, exp[i]); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_multi_lm();
    test_single_sm();
    test_stall();
    test_flush();
    test_empty_list();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
